// File: rtl/frame_scheduler.sv
// frame_scheduler: derives the frame boundary from the 1 ms clock and shares one update slot round-robin.
// Latency: grant is registered; the first grant follows frame_tick by 1 cycle, with one PICK cycle between grants.
// Backpressure: none; a stuck requester is cut by the slot timeout, and unfinished work is dropped at the boundary.
module frame_scheduler #(
  parameter int FRAME_MS     = 20,
  parameter int N_REQ        = 4,
  parameter int SLOT_TIMEOUT = 4
) (
  input  logic             clk_1ms,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             frame_tick,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       overrun_cnt,
  output logic [N_REQ-1:0] timeout_flags,
  output logic [7:0]       frame_num
);

  localparam int CW = $clog2(FRAME_MS);
  localparam int PW = $clog2(N_REQ);
  localparam int SW = (SLOT_TIMEOUT > 1) ? $clog2(SLOT_TIMEOUT) : 1;

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_MS - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(N_REQ - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    frame_cnt;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    rr_use;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pending_nxt;
  logic [SW-1:0]    slot_cnt;
  logic [SW-1:0]    slot_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [N_REQ-1:0] flags_nxt;
  logic             boundary;
  logic             done_hit;
  logic             overrun_hit;
  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    cand;

  assign boundary = enable && (frame_cnt == FRAME_LAST);
  assign done_hit = |(done & grant);
  assign busy     = (state != IDLE);

  // Unfinished work at a boundary: a slot still held, or requesters not yet served.
  assign overrun_hit = boundary &&
                       (((state == GRANT) && !done_hit) ||
                        ((state != IDLE) && (pending != '0)));

  // Round-robin scan of pending, starting at this frame's pointer and wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(rr_use) + k) % N_REQ);
      if (!pick_found && pending[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_1ms) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and slot datapath; the boundary is applied last so it overrides the FSM.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    pending_nxt = pending;
    slot_nxt    = slot_cnt;
    flags_nxt   = timeout_flags;
    case (state)
      IDLE: begin
        grant_nxt = '0;
      end
      PICK: begin
        if (pick_found) begin
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          pending_nxt[pick_idx] = 1'b0;
          slot_nxt            = '0;
          state_nxt           = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (done_hit) begin
          grant_nxt = '0;
          state_nxt = PICK;
        end else if (slot_cnt == SLOT_LAST) begin
          flags_nxt = timeout_flags | grant;
          grant_nxt = '0;
          state_nxt = PICK;
        end else begin
          slot_nxt = slot_cnt + SW'(1);
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
    if (boundary) begin
      grant_nxt   = '0;
      pending_nxt = req;
      state_nxt   = PICK;
    end
  end

  // Frame counter, round-robin pointer, slot registers and status outputs.
  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      frame_cnt     <= '0;
      frame_num     <= '0;
      frame_tick    <= 1'b0;
      rr_ptr        <= '0;
      rr_use        <= '0;
      pending       <= '0;
      slot_cnt      <= '0;
      grant         <= '0;
      timeout_flags <= '0;
      overrun       <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      grant         <= grant_nxt;
      pending       <= pending_nxt;
      slot_cnt      <= slot_nxt;
      timeout_flags <= flags_nxt;
      frame_tick    <= boundary;
      overrun       <= overrun_hit;
      if (overrun_hit && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      if (boundary) begin
        frame_cnt <= '0;
        frame_num <= frame_num + 8'd1;
        rr_use    <= rr_ptr;
        rr_ptr    <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + PW'(1);
      end else if (enable) begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: checks two scheduler instances (slot timeout 4 and 6) against a frame-level model.
// Latency: outputs compared every cycle on the falling edge; directed literals checked 1 time unit after rising edges.
// Backpressure: n/a; done is driven by the bench, reactively in the round-robin section.
module tb_frame_scheduler;
  localparam int FRAME_MS = 20;
  localparam int N = 4;

  logic       clk_1ms = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] done = 4'b0;
  logic [3:0] grant_a, grant_b, flags_a, flags_b;
  logic       tick_a, tick_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [7:0] ocnt_a, ocnt_b, fnum_a, fnum_b;

  int checks = 0;
  int passes = 0;
  bit chk_on = 1'b0;
  bit auto_done = 1'b0;

  always #5 clk_1ms = ~clk_1ms;

  frame_scheduler #(.FRAME_MS(FRAME_MS), .N_REQ(N), .SLOT_TIMEOUT(4)) dut_a (
    .clk_1ms(clk_1ms), .reset(reset), .enable(enable), .req(req), .done(done),
    .grant(grant_a), .frame_tick(tick_a), .busy(busy_a), .overrun(ovr_a),
    .overrun_cnt(ocnt_a), .timeout_flags(flags_a), .frame_num(fnum_a)
  );

  frame_scheduler #(.FRAME_MS(FRAME_MS), .N_REQ(N), .SLOT_TIMEOUT(6)) dut_b (
    .clk_1ms(clk_1ms), .reset(reset), .enable(enable), .req(req), .done(done),
    .grant(grant_b), .frame_tick(tick_b), .busy(busy_b), .overrun(ovr_b),
    .overrun_cnt(ocnt_b), .timeout_flags(flags_b), .frame_num(fnum_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Frame-level model: an ordered list of who still needs a slot, the current owner and its age.
  int         m_owner[2], m_age[2], m_pos[2], m_rr[2], m_fnum[2], m_ocnt[2], m_head[2], m_len[2];
  bit         m_pick[2], m_tick[2], m_ovr[2];
  logic [3:0] m_flags[2];
  int         m_ord[2][4];

  task automatic model_step(input int m, input int tmo);
    bit bnd, fin, unfinished;
    int i;
    m_tick[m] = 1'b0;
    m_ovr[m]  = 1'b0;
    if (reset) begin
      m_owner[m] = -1; m_age[m] = 0; m_pos[m] = 0; m_rr[m] = 0; m_fnum[m] = 0;
      m_ocnt[m] = 0; m_head[m] = 0; m_len[m] = 0; m_pick[m] = 1'b0; m_flags[m] = 4'b0;
    end else begin
      bnd = enable && (m_pos[m] == FRAME_MS - 1);
      fin = (m_owner[m] >= 0) && done[m_owner[m]];
      unfinished = ((m_owner[m] >= 0) && !fin) || (m_head[m] < m_len[m]);
      if (m_owner[m] >= 0) begin
        if (fin) begin
          m_owner[m] = -1;
          m_pick[m] = 1'b1;
        end else if (m_age[m] == tmo) begin
          m_flags[m][m_owner[m]] = 1'b1;
          m_owner[m] = -1;
          m_pick[m] = 1'b1;
        end else begin
          m_age[m]++;
        end
      end else if (m_pick[m]) begin
        if (m_head[m] < m_len[m]) begin
          m_owner[m] = m_ord[m][m_head[m]];
          m_head[m]++;
          m_age[m] = 1;
        end
        m_pick[m] = 1'b0;
      end
      if (bnd) begin
        if (unfinished) begin
          m_ovr[m] = 1'b1;
          if (m_ocnt[m] < 255) m_ocnt[m]++;
        end
        m_owner[m] = -1;
        m_head[m] = 0;
        m_len[m] = 0;
        for (int k = 0; k < N; k++) begin
          i = (m_rr[m] + k) % N;
          if (req[i]) begin
            m_ord[m][m_len[m]] = i;
            m_len[m]++;
          end
        end
        m_rr[m]   = (m_rr[m] + 1) % N;
        m_pick[m] = 1'b1;
        m_tick[m] = 1'b1;
        m_pos[m]  = 0;
        m_fnum[m] = (m_fnum[m] + 1) % 256;
      end else if (enable) begin
        m_pos[m]++;
      end
    end
  endtask

  function automatic int m_grant(input int m);
    return (m_owner[m] >= 0) ? (1 << m_owner[m]) : 0;
  endfunction

  // Model advances on the same edge as the DUTs, from the same sampled inputs.
  always @(posedge clk_1ms) begin
    model_step(0, 4);
    model_step(1, 6);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk_1ms) begin
    if (chk_on) begin
      check("grant_a", grant_a, m_grant(0));
      check("tick_a", tick_a, m_tick[0]);
      check("busy_a", busy_a, int'(m_pick[0] || (m_owner[0] >= 0)));
      check("overrun_a", ovr_a, m_ovr[0]);
      check("ocnt_a", ocnt_a, m_ocnt[0]);
      check("flags_a", flags_a, m_flags[0]);
      check("fnum_a", fnum_a, m_fnum[0]);
      check("grant_b", grant_b, m_grant(1));
      check("tick_b", tick_b, m_tick[1]);
      check("busy_b", busy_b, int'(m_pick[1] || (m_owner[1] >= 0)));
      check("overrun_b", ovr_b, m_ovr[1]);
      check("ocnt_b", ocnt_b, m_ocnt[1]);
      check("flags_b", flags_b, m_flags[1]);
      check("fnum_b", fnum_b, m_fnum[1]);
    end
  end

  // Advance n rising edges; optionally answer the grant of instance a one cycle after it rises.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1ms);
      #1;
      if (auto_done) done = (m_owner[0] >= 0 && m_age[0] == 2) ? 4'(1 << m_owner[0]) : 4'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] got[6];
    logic [3:0] prev, acc;
    int cnt, hi, n;
    bit found;

    // Reset state.
    @(posedge clk_1ms);
    #1;
    chk_on = 1'b1;
    step(1);
    check("rst_grant", grant_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fnum", fnum_a, 0);
    check("rst_flags", flags_a, 0);
    check("rst_ocnt", ocnt_a, 0);

    // Idle frames.
    reset = 1'b0; enable = 1'b1; req = 4'b0;
    step(19);
    check("idle_tick19", tick_a, 0);
    step(1);
    check("idle_tick20", tick_a, 1);
    check("idle_fnum1", fnum_a, 1);
    step(20);
    check("idle_tick40", tick_a, 1);
    check("idle_fnum2", fnum_a, 2);
    check("idle_grant", grant_a, 0);

    // Round-robin order with done one cycle after each grant rises.
    reset = 1'b1; step(1); reset = 1'b0;
    req = 4'b1011; auto_done = 1'b1;
    for (int j = 0; j < 6; j++) got[j] = 4'b0;
    cnt = 0; prev = 4'b0;
    for (int c = 1; c <= 58; c++) begin
      step(1);
      if (grant_a != 4'b0 && prev == 4'b0 && cnt < 6) begin
        got[cnt] = grant_a;
        cnt++;
      end
      prev = grant_a;
    end
    auto_done = 1'b0; done = 4'b0;
    check("rr_count", cnt, 6);
    check("rr_f1_0", got[0], 4'b0001);
    check("rr_f1_1", got[1], 4'b0010);
    check("rr_f1_2", got[2], 4'b1000);
    check("rr_f2_0", got[3], 4'b0010);
    check("rr_f2_1", got[4], 4'b1000);
    check("rr_f2_2", got[5], 4'b0001);
    check("rr_ocnt", ocnt_a, 0);

    // Slot timeout.
    reset = 1'b1; step(1); reset = 1'b0;
    req = 4'b0001; done = 4'b0;
    hi = 0;
    for (int c = 1; c <= 30; c++) begin
      step(1);
      if (grant_a[0]) hi++;
      if (c == 24) check("to_grant24", grant_a, 4'b0001);
      if (c == 25) begin
        check("to_grant25", grant_a, 0);
        check("to_flags25", flags_a, 4'b0001);
      end
      if (c == 26) check("to_busy26", busy_a, 0);
    end
    check("to_high_cycles", hi, 4);
    step(20);
    check("to_flags_persist", flags_a, 4'b0001);

    // Overrun on the SLOT_TIMEOUT=6 instance.
    reset = 1'b1; step(1); reset = 1'b0;
    req = 4'b1111; done = 4'b0;
    acc = 4'b0;
    for (int c = 1; c <= 39; c++) begin
      step(1);
      if (c > 20) acc = acc | grant_b;
    end
    check("ov_granted_f1", acc, 4'b0111);
    check("ov_grant39", grant_b, 4'b0100);
    check("ov_pulse_pre", ovr_b, 0);
    step(1);
    check("ov_pulse", ovr_b, 1);
    check("ov_cnt", ocnt_b, 1);
    check("ov_grant_cut", grant_b, 0);
    check("ov_flags", flags_b, 4'b0011);
    step(1);
    check("ov_pulse_end", ovr_b, 0);
    check("ov_f2_grant", grant_b, 4'b0010);

    // Reset mid-grant.
    reset = 1'b1; step(1);
    check("mr_grant", grant_b, 0);
    check("mr_busy", busy_b, 0);
    check("mr_ocnt", ocnt_b, 0);
    check("mr_flags", flags_b, 0);
    check("mr_fnum", fnum_b, 0);
    reset = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      step(1);
      n++;
      if (tick_b) found = 1'b1;
    end
    check("mr_tick_delay", n, 20);

    // Enable hold delays the boundary; a grant still completes with enable low.
    reset = 1'b1; step(1); reset = 1'b0;
    req = 4'b0010; done = 4'b0; enable = 1'b1;
    step(10);
    enable = 1'b0; step(5); enable = 1'b1;
    step(5);
    check("en_tick20", tick_a, 0);
    step(5);
    check("en_tick25", tick_a, 1);
    check("en_fnum", fnum_a, 1);
    enable = 1'b0;
    step(1);
    check("en_grant", grant_a, 4'b0010);
    done = 4'b0010;
    step(1);
    check("en_grant_done", grant_a, 0);
    check("en_flags", flags_a, 0);
    check("en_fnum_hold", fnum_a, 1);
    done = 4'b0; enable = 1'b1;
    step(5);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Frame-rate scheduler for the game logic. It generates the 20 ms frame boundary from the 1 ms clock. Within each frame it shares the single update slot among up to N_REQ game-object updaters (player, demons, bullets, score) through a one-hot request/grant/done handshake. Grant order is round-robin, and a per-slot timeout and overrun detection keep one stuck object from stalling the frame.

## Interface
- FRAME_MS, 20: frame period in clk_1ms cycles (≥ 2)
- N_REQ, 4: number of requesters (2..8)
- SLOT_TIMEOUT, 4: maximum grant length in cycles (≥ 1)
- clk_1ms  in  1  clock, 1 ms period, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  frame counter advances only while high
- req  in  N_REQ  per-requester "needs update this frame"
- done  in  N_REQ  per-requester completion, honoured only while the matching grant bit is high
- grant  out  N_REQ  one-hot or zero, registered
- frame_tick  out  1  one-cycle pulse at each frame boundary
- busy  out  1  high while the frame's work is pending or granted
- overrun  out  1  one-cycle pulse when a boundary arrives with work unfinished
- overrun_cnt  out  8  saturating count of overruns
- timeout_flags  out  N_REQ  sticky, bit i set when requester i's slot timed out
- frame_num  out  8  frames elapsed, wraps 255→0

## Operation
- Reset values: every output is 0, frame_cnt is 0, rr_ptr is 0, pending is 0, state is IDLE.
- frame_cnt has width clog2(FRAME_MS).
  - It increments on every enabled cycle.
  - When frame_cnt==FRAME_MS-1 and enable=1, that edge is a boundary: frame_cnt→0, frame_tick→1 for one cycle, and frame_num increments.
  - With enable=0, frame_cnt and frame_num hold. The current frame's work still completes.
- At every boundary:
  - pending ← req, sampled on that edge.
  - rr_ptr in use ← current rr_ptr, then rr_ptr ← (rr_ptr+1) mod N_REQ.
  - State ← PICK.
- FSM states:
  - **IDLE**: grant=0, busy=0. Waits for a boundary.
  - **PICK**:
    - If pending==0: go to IDLE.
    - Otherwise, select the first set pending bit scanning rr_ptr, rr_ptr+1, … with wrap.
    - Set that grant bit, clear its pending bit, clear slot_cnt, go to GRANT.
  - **GRANT**:
    - slot_cnt increments each cycle.
    - If done[i] & grant[i]: grant→0, go to PICK.
    - Else if slot_cnt reaches SLOT_TIMEOUT-1 (the grant has been high SLOT_TIMEOUT cycles): grant→0, timeout_flags[i]→1, go to PICK.
- busy = (state≠IDLE).
- Overrun:
  - Condition: a boundary occurs while state==GRANT, or while state==PICK with pending≠0.
  - On that edge: overrun pulses, overrun_cnt increments (saturating at 255), any grant drops to 0, leftover pending bits are discarded, and the new snapshot is taken.
- Simultaneous events:
  - done and timeout on the same edge: counts as done, no flag set.
  - done and boundary on the same edge: counts as completion. Overrun fires only if pending was still nonzero.
  - Boundary is evaluated last and overrides the FSM's next state.
- done bits for requesters that are not granted are ignored.
- timeout_flags clear only on reset.

## Timing
- First frame_tick comes FRAME_MS cycles after reset deasserts (with enable held high). After that, one frame_tick every FRAME_MS enabled cycles.
- The first grant of a frame rises 1 cycle after frame_tick rises.
- Grant deasserts on the edge that samples done. The next grant rises 1 cycle later, because of one PICK cycle.
- Each serviced requester therefore costs (cycles until done)+1. A timed-out requester costs SLOT_TIMEOUT+1.
- Reset mid-operation: on the next edge every output is 0 and all state is cleared, regardless of FSM state.

## Test plan
- **Idle frames.** Reset, enable=1, req=0 → frame_tick at cycles 20 and 40 after reset release, frame_num=1 then 2, grant stays 0, busy stays 0.
- **Round-robin order.** req=4'b1011 held; each granted requester asserts done 1 cycle after its grant rises.
  - Frame 1 grant order: 0001, 0010, 1000.
  - Frame 2 grant order: 0010, 1000, 0001.
  - overrun stays 0.
- **Slot timeout.** req=4'b0001, done held 0 → grant[0] high exactly 4 cycles, timeout_flags=0001, busy=0 from the following cycle. The flag persists through later frames.
- **Overrun.** Instance with SLOT_TIMEOUT=6, req=4'b1111, done=0.
  - Frame 1: requesters 0 and 1 time out; grant[2] is cut at the boundary; requester 3 is never granted.
  - At the boundary: overrun pulses 1 cycle, overrun_cnt=1.
  - Frame 2 starts with grant 0010.
- **Reset mid-grant.** Assert reset while grant=0010 → next edge: grant, busy, and all counters and flags are 0. Next frame_tick comes 20 cycles after release.
- **Enable hold.** Deassert enable for 5 cycles at frame_cnt=10 → that frame's boundary is delayed by exactly 5 cycles, and an active grant still completes on done.
